// File: rtl/sdram_tx_pkg.sv
// sdram_tx_pkg: shared field positions, encodings, FSM states and burst helpers
// for the SDRAM-side tx command fetcher. Rev 1.0
`default_nettype none

package sdram_tx_pkg;

  localparam int HDR_ADR_MSB = 35;
  localparam int HDR_ADR_LSB = 6;
  localparam int HDR_WE      = 5;
  localparam int HDR_BTE_MSB = 4;
  localparam int HDR_BTE_LSB = 3;
  localparam int HDR_CTI_MSB = 2;
  localparam int HDR_CTI_LSB = 0;

  localparam int DAT_MSB = 35;
  localparam int DAT_LSB = 4;
  localparam int SEL_MSB = 3;
  localparam int SEL_LSB = 0;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR = 2'b00;
  localparam logic [1:0] BTE_WRAP4  = 2'b01;
  localparam logic [1:0] BTE_WRAP8  = 2'b10;
  localparam logic [1:0] BTE_WRAP16 = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HDR_RD  = 3'd1,
    ST_HDR_CAP = 3'd2,
    ST_DAT_RD  = 3'd3,
    ST_DAT_CAP = 3'd4,
    ST_ISSUE   = 3'd5
  } state_e;

  function automatic logic cti_reserved(input logic [2:0] cti);
    return !((cti == CTI_CLASSIC) || (cti == CTI_INCR) || (cti == CTI_EOB));
  endfunction

  // Anything other than an incrementing burst is a single beat.
  function automatic logic [4:0] beat_count(input logic [2:0] cti,
                                            input logic [1:0] bte,
                                            input logic [4:0] linear_len);
    logic [4:0] n;
    n = 5'd1;
    if (cti == CTI_INCR) begin
      case (bte)
        BTE_LINEAR: n = linear_len;
        BTE_WRAP4:  n = 5'd4;
        BTE_WRAP8:  n = 5'd8;
        default:    n = 5'd16;
      endcase
    end
    return n;
  endfunction

  function automatic logic [29:0] next_adr(input logic [29:0] adr,
                                           input logic [1:0]  bte);
    logic [29:0] a;
    case (bte)
      BTE_WRAP4:  a = {adr[29:2], adr[1:0] + 2'd1};
      BTE_WRAP8:  a = {adr[29:3], adr[2:0] + 3'd1};
      BTE_WRAP16: a = {adr[29:4], adr[3:0] + 4'd1};
      default:    a = adr + 30'd1;
    endcase
    return a;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arb8.sv
// rr_arb8: combinational round-robin pick of the first request above ptr_i,
// wrapping modulo 8. Rev 1.0
`default_nettype none

module rr_arb8 (
  input  logic [7:0] req_i,
  input  logic [2:0] ptr_i,
  output logic       any_o,
  output logic [2:0] gnt_o
);

  logic       found;
  logic [2:0] idx;

  always_comb begin
    found = 1'b0;
    idx   = 3'd0;
    gnt_o = 3'd0;
    // i = 8 wraps back onto ptr_i itself, so it is checked last.
    for (int i = 1; i <= 8; i++) begin
      idx = ptr_i + i[2:0];
      if (!found && req_i[idx]) begin
        found = 1'b1;
        gnt_o = idx;
      end
    end
  end

  assign any_o = |req_i;

endmodule

`default_nettype wire

// File: rtl/sdram_tx_cmd_fetch.sv
// sdram_tx_cmd_fetch: pops Wishbone headers/data from the multi-channel tx FIFO
// and expands each header into a per-beat request stream. Rev 1.0
`default_nettype none

module sdram_tx_cmd_fetch
  import sdram_tx_pkg::*;
#(
  parameter logic [7:0] PORT_MASK  = 8'hFF,
  parameter int         LINEAR_LEN = 8
) (
  input  logic        sdram_clk,
  input  logic        sdram_rst_n,
  input  logic [7:0]  b_fifo_empty_i,
  input  logic [35:0] b_dat_i,
  output logic        b_re_o,
  output logic [2:0]  b_fifo_sel_o,
  output logic        req_valid_o,
  input  logic        req_ready_i,
  output logic [29:0] req_adr_o,
  output logic        req_we_o,
  output logic [31:0] req_dat_o,
  output logic [3:0]  req_sel_o,
  output logic [2:0]  req_port_o,
  output logic        req_last_o,
  output logic        busy_o,
  output logic        err_o
);

  localparam logic [4:0] LIN_LEN = 5'(LINEAR_LEN);

  state_e      state_q, state_d;
  logic [2:0]  port_q, port_d;
  logic [2:0]  rr_ptr_q, rr_ptr_d;
  logic [29:0] adr_q, adr_d;
  logic        we_q, we_d;
  logic [1:0]  bte_q, bte_d;
  logic [31:0] dat_q, dat_d;
  logic [3:0]  sel_q, sel_d;
  logic [4:0]  beats_q, beats_d;
  logic [4:0]  beat_cnt_q, beat_cnt_d;

  logic        arb_any;
  logic [2:0]  arb_gnt;
  logic        port_empty;
  logic        is_last;
  logic [2:0]  hdr_cti;
  logic [1:0]  hdr_bte;

  rr_arb8 u_arb (
    .req_i (~b_fifo_empty_i & PORT_MASK),
    .ptr_i (rr_ptr_q),
    .any_o (arb_any),
    .gnt_o (arb_gnt)
  );

  assign port_empty = b_fifo_empty_i[port_q];
  assign is_last    = (beat_cnt_q == (beats_q - 5'd1));
  assign hdr_cti    = b_dat_i[HDR_CTI_MSB:HDR_CTI_LSB];
  assign hdr_bte    = b_dat_i[HDR_BTE_MSB:HDR_BTE_LSB];

  always_ff @(posedge sdram_clk) begin
    if (!sdram_rst_n) begin
      state_q    <= ST_IDLE;
      port_q     <= 3'd0;
      rr_ptr_q   <= 3'd7;
      adr_q      <= 30'd0;
      we_q       <= 1'b0;
      bte_q      <= 2'd0;
      dat_q      <= 32'd0;
      sel_q      <= 4'd0;
      beats_q    <= 5'd0;
      beat_cnt_q <= 5'd0;
    end else begin
      state_q    <= state_d;
      port_q     <= port_d;
      rr_ptr_q   <= rr_ptr_d;
      adr_q      <= adr_d;
      we_q       <= we_d;
      bte_q      <= bte_d;
      dat_q      <= dat_d;
      sel_q      <= sel_d;
      beats_q    <= beats_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    port_d      = port_q;
    rr_ptr_d    = rr_ptr_q;
    adr_d       = adr_q;
    we_d        = we_q;
    bte_d       = bte_q;
    dat_d       = dat_q;
    sel_d       = sel_q;
    beats_d     = beats_q;
    beat_cnt_d  = beat_cnt_q;
    b_re_o      = 1'b0;
    req_valid_o = 1'b0;
    req_last_o  = 1'b0;
    err_o       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          port_d  = arb_gnt;
          state_d = ST_HDR_RD;
        end
      end
      // Pops are gated on the selected channel's flag even for the header,
      // in case it drained between arbitration and the read.
      ST_HDR_RD: begin
        if (!port_empty) begin
          b_re_o  = 1'b1;
          state_d = ST_HDR_CAP;
        end
      end
      ST_HDR_CAP: begin
        adr_d      = b_dat_i[HDR_ADR_MSB:HDR_ADR_LSB];
        we_d       = b_dat_i[HDR_WE];
        bte_d      = hdr_bte;
        beats_d    = beat_count(hdr_cti, hdr_bte, LIN_LEN);
        beat_cnt_d = 5'd0;
        err_o      = cti_reserved(hdr_cti);
        if (b_dat_i[HDR_WE]) begin
          state_d = ST_DAT_RD;
        end else begin
          dat_d   = 32'd0;
          sel_d   = 4'hF;
          state_d = ST_ISSUE;
        end
      end
      ST_DAT_RD: begin
        if (!port_empty) begin
          b_re_o  = 1'b1;
          state_d = ST_DAT_CAP;
        end
      end
      ST_DAT_CAP: begin
        dat_d   = b_dat_i[DAT_MSB:DAT_LSB];
        sel_d   = b_dat_i[SEL_MSB:SEL_LSB];
        state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        req_valid_o = 1'b1;
        req_last_o  = is_last;
        if (req_ready_i) begin
          if (is_last) begin
            rr_ptr_d = port_q;
            state_d  = ST_IDLE;
          end else begin
            adr_d      = next_adr(adr_q, bte_q);
            beat_cnt_d = beat_cnt_q + 5'd1;
            state_d    = we_q ? ST_DAT_RD : ST_ISSUE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign b_fifo_sel_o = port_q;
  assign req_adr_o    = adr_q;
  assign req_we_o     = we_q;
  assign req_dat_o    = dat_q;
  assign req_sel_o    = sel_q;
  assign req_port_o   = port_q;
  assign busy_o       = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_sdram_tx_cmd_fetch.sv
// tb_sdram_tx_cmd_fetch: directed scenarios against a small FIFO model.
`default_nettype none

module tb_sdram_tx_cmd_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  empty;
  logic [35:0] b_dat = '0;
  logic        b_re;
  logic [2:0]  fsel;
  logic        rv;
  logic        ready = 1'b1;
  logic [29:0] adr;
  logic        we;
  logic [31:0] dat;
  logic [3:0]  sel;
  logic [2:0]  port;
  logic        last;
  logic        busy;
  logic        err;

  logic [7:0]  empty_m;
  logic [35:0] b_dat_m;
  logic        b_re_m, rv_m, we_m, last_m, busy_m, err_m;
  logic [2:0]  fsel_m, port_m;
  logic [29:0] adr_m;
  logic [31:0] dat_m;
  logic [3:0]  sel_m;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  sdram_tx_cmd_fetch #(.PORT_MASK(8'hFF), .LINEAR_LEN(8)) dut (
    .sdram_clk(clk), .sdram_rst_n(rst_n), .b_fifo_empty_i(empty), .b_dat_i(b_dat),
    .b_re_o(b_re), .b_fifo_sel_o(fsel), .req_valid_o(rv), .req_ready_i(ready),
    .req_adr_o(adr), .req_we_o(we), .req_dat_o(dat), .req_sel_o(sel),
    .req_port_o(port), .req_last_o(last), .busy_o(busy), .err_o(err)
  );

  sdram_tx_cmd_fetch #(.PORT_MASK(8'hFB), .LINEAR_LEN(8)) dut_m (
    .sdram_clk(clk), .sdram_rst_n(rst_n), .b_fifo_empty_i(empty_m), .b_dat_i(b_dat_m),
    .b_re_o(b_re_m), .b_fifo_sel_o(fsel_m), .req_valid_o(rv_m), .req_ready_i(1'b1),
    .req_adr_o(adr_m), .req_we_o(we_m), .req_dat_o(dat_m), .req_sel_o(sel_m),
    .req_port_o(port_m), .req_last_o(last_m), .busy_o(busy_m), .err_o(err_m)
  );

  // Masked instance: channels 0, 2, 6 permanently hold single-read headers.
  assign empty_m = 8'b1011_1010;
  assign b_dat_m = 36'h0;

  // FIFO model for the main instance: one active channel plus a round-robin mode.
  logic [35:0] mem [0:63];
  int          wr_cnt = 0;
  int          rd_idx = 0;
  logic [2:0]  fifo_ch = 3'd0;
  logic        rr_mode = 1'b0;
  int          pop_cnt = 0;
  int          bad_pop = 0;
  int          err_cnt = 0;

  assign empty = rr_mode ? 8'b1011_1010 :
                 ((rd_idx < wr_cnt) ? ~(8'h01 << fifo_ch) : 8'hFF);

  always @(posedge clk) begin
    if (b_re) begin
      pop_cnt <= pop_cnt + 1;
      if (empty[fsel]) bad_pop <= bad_pop + 1;
      if (rr_mode) begin
        b_dat <= 36'h0;
      end else begin
        b_dat  <= mem[rd_idx[5:0]];
        rd_idx <= rd_idx + 1;
      end
    end
    if (b_re_m && empty_m[fsel_m]) bad_pop <= bad_pop + 1;
    if (err) err_cnt <= err_cnt + 1;
  end

  function automatic logic [35:0] hdr(input logic [29:0] a, input logic w,
                                      input logic [1:0] bte, input logic [2:0] cti);
    return {a, w, bte, cti};
  endfunction

  function automatic logic [35:0] dword(input int i);
    return {32'hD000_0000 + 32'(i), 4'(i * 3 + 1)};
  endfunction

  task automatic push(input logic [35:0] w);
    mem[wr_cnt[5:0]] = w;
    wr_cnt = wr_cnt + 1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_beat(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!rv && cyc < 40);
    if (!rv) begin
      vectors++; miscompares++;
      $display("FAIL beat_timeout got req_valid_o=0 want 1 within 40 cycles");
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    vectors++;
    if ({b_re, fsel, rv, adr, we, dat, sel, port, last, busy, err} !== 78'd0) begin
      miscompares++;
      $display("FAIL reset_outputs got %h want 0",
               {b_re, fsel, rv, adr, we, dat, sel, port, last, busy, err});
    end
    vectors++;
    if (dut.rr_ptr_q !== 3'd7) begin
      miscompares++; $display("FAIL reset_rr_ptr got %0d want 7", dut.rr_ptr_q);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single_read();
    int cyc, p0;
    apply_reset();
    p0 = pop_cnt;
    fifo_ch = 3'd3;
    push(hdr(30'h123, 1'b0, 2'b00, 3'b000));
    wait_beat(cyc);
    vectors++;
    if (cyc !== 3) begin miscompares++; $display("FAIL rd_latency got %0d want 3", cyc); end
    vectors++;
    if ({adr, we, dat, sel, port, last, fsel} !== {30'h123, 1'b0, 32'h0, 4'hF, 3'd3, 1'b1, 3'd3}) begin
      miscompares++;
      $display("FAIL single_beat got adr=%h we=%b dat=%h sel=%h port=%0d last=%b fsel=%0d want adr=123 we=0 dat=0 sel=f port=3 last=1 fsel=3",
               adr, we, dat, sel, port, last, fsel);
    end
    @(negedge clk);
    vectors++;
    if ({busy, 32'(pop_cnt - p0)} !== {1'b0, 32'd1}) begin
      miscompares++; $display("FAIL single_end got busy=%b pops=%0d want busy=0 pops=1", busy, pop_cnt - p0);
    end
    vectors++;
    if (dut.rr_ptr_q !== 3'd3) begin
      miscompares++; $display("FAIL single_rr_ptr got %0d want 3", dut.rr_ptr_q);
    end
  endtask

  task automatic test_wrap4_read();
    int cyc;
    logic [29:0] e;
    apply_reset();
    fifo_ch = 3'd1;
    push(hdr(30'h46, 1'b0, 2'b01, 3'b010));
    for (int i = 0; i < 4; i++) begin
      wait_beat(cyc);
      e = 30'h44 | 30'((2 + i) % 4);
      vectors++;
      if ({adr, last, port} !== {e, (i == 3), 3'd1}) begin
        miscompares++;
        $display("FAIL wrap4_beat%0d got adr=%h last=%b port=%0d want adr=%h last=%b port=1", i, adr, last, port, e, (i == 3));
      end
      vectors++;
      if (cyc !== ((i == 0) ? 3 : 1)) begin
        miscompares++; $display("FAIL wrap4_spacing%0d got %0d want %0d", i, cyc, (i == 0) ? 3 : 1);
      end
    end
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL wrap4_idle got busy=%b want 0", busy); end
  endtask

  task automatic test_linear_read();
    int cyc;
    logic [29:0] e;
    apply_reset();
    fifo_ch = 3'd0;
    push(hdr(30'h3FFF_FFFE, 1'b0, 2'b00, 3'b010));
    for (int i = 0; i < 8; i++) begin
      wait_beat(cyc);
      e = 30'h3FFF_FFFE + 30'(i);
      vectors++;
      if ({adr, last} !== {e, (i == 7)}) begin
        miscompares++;
        $display("FAIL linear_beat%0d got adr=%h last=%b want adr=%h last=%b", i, adr, last, e, (i == 7));
      end
    end
  endtask

  task automatic test_wrap8_write();
    int cyc, p0;
    logic [29:0] e;
    apply_reset();
    p0 = pop_cnt;
    fifo_ch = 3'd5;
    push(hdr(30'h105, 1'b1, 2'b10, 3'b010));
    for (int i = 0; i < 8; i++) push(dword(i));
    for (int i = 0; i < 8; i++) begin
      wait_beat(cyc);
      e = 30'h100 | 30'((5 + i) % 8);
      vectors++;
      if ({adr, we, dat, sel, port, last} !==
          {e, 1'b1, 32'hD000_0000 + 32'(i), 4'(i * 3 + 1), 3'd5, (i == 7)}) begin
        miscompares++;
        $display("FAIL wr8_beat%0d got adr=%h we=%b dat=%h sel=%h port=%0d last=%b want adr=%h dat=%h sel=%h",
                 i, adr, we, dat, sel, port, last, e, 32'hD000_0000 + 32'(i), 4'(i * 3 + 1));
      end
      vectors++;
      if (cyc !== ((i == 0) ? 5 : 3)) begin
        miscompares++; $display("FAIL wr8_spacing%0d got %0d want %0d", i, cyc, (i == 0) ? 5 : 3);
      end
    end
    @(negedge clk);
    vectors++;
    if ({busy, 32'(pop_cnt - p0)} !== {1'b0, 32'd9}) begin
      miscompares++; $display("FAIL wr8_end got busy=%b pops=%0d want busy=0 pops=9", busy, pop_cnt - p0);
    end
  endtask

  task automatic test_underflow_backpressure();
    int k, bp, cyc;
    logic [29:0] e;
    apply_reset();
    fifo_ch = 3'd5;
    push(hdr(30'h3FFF_FFFA, 1'b1, 2'b10, 3'b010));
    for (int i = 0; i < 2; i++) push(dword(i));
    k = 0; bp = 4; cyc = 0;
    while (k < 2 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (rv) begin
        e = 30'h3FFF_FFF8 | 30'((2 + k) % 8);
        vectors++;
        if ({adr, dat, sel, port} !== {e, 32'hD000_0000 + 32'(k), 4'(k * 3 + 1), 3'd5}) begin
          miscompares++;
          $display("FAIL bp_hold%0d got adr=%h dat=%h sel=%h port=%0d want adr=%h dat=%h", k, adr, dat, sel, port, e, 32'hD000_0000 + 32'(k));
        end
        if (k == 1 && bp > 0) begin
          ready = 1'b0;
          bp--;
        end else begin
          ready = 1'b1;
          k++;
        end
      end
    end
    vectors++;
    if (k !== 2) begin miscompares++; $display("FAIL bp_progress got %0d beats want 2", k); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      vectors++;
      if ({b_re, rv, busy} !== 3'b001) begin
        miscompares++; $display("FAIL underflow_stall%0d got re=%b valid=%b busy=%b want 0 0 1", i, b_re, rv, busy);
      end
    end
    for (int i = 2; i < 8; i++) push(dword(i));
    for (int i = 2; i < 8; i++) begin
      wait_beat(cyc);
      e = 30'h3FFF_FFF8 | 30'((2 + i) % 8);
      vectors++;
      if ({adr, dat, sel, last} !== {e, 32'hD000_0000 + 32'(i), 4'(i * 3 + 1), (i == 7)}) begin
        miscompares++;
        $display("FAIL uf_beat%0d got adr=%h dat=%h sel=%h last=%b want adr=%h dat=%h", i, adr, dat, sel, last, e, 32'hD000_0000 + 32'(i));
      end
    end
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL uf_idle got busy=%b want 0", busy); end
  endtask

  task automatic test_round_robin();
    int cyc;
    logic [2:0] exp_rr [4];
    exp_rr = '{3'd0, 3'd2, 3'd6, 3'd0};
    apply_reset();
    rr_mode = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_beat(cyc);
      vectors++;
      if (port !== exp_rr[i]) begin
        miscompares++; $display("FAIL rr_grant%0d got %0d want %0d", i, port, exp_rr[i]);
      end
    end
    rr_mode = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_port_mask();
    int k, cyc;
    logic [2:0] exp_m [4];
    exp_m = '{3'd0, 3'd6, 3'd0, 3'd6};
    apply_reset();
    k = 0; cyc = 0;
    while (k < 4 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (rv_m) begin
        vectors++;
        if ({port_m, adr_m, we_m, dat_m, sel_m, last_m, busy_m, err_m} !==
            {exp_m[k], 30'h0, 1'b0, 32'h0, 4'hF, 1'b1, 1'b1, 1'b0}) begin
          miscompares++;
          $display("FAIL mask_grant%0d got port=%0d sel=%h last=%b want port=%0d sel=f last=1", k, port_m, sel_m, last_m, exp_m[k]);
        end
        k++;
      end
    end
    vectors++;
    if (k !== 4) begin miscompares++; $display("FAIL mask_progress got %0d grants want 4", k); end
  endtask

  task automatic test_reserved_cti();
    int cyc, e0;
    apply_reset();
    e0 = err_cnt;
    fifo_ch = 3'd1;
    push(hdr(30'h77, 1'b0, 2'b00, 3'b011));
    repeat (2) @(negedge clk);
    vectors++;
    if (err !== 1'b1) begin miscompares++; $display("FAIL err_pulse got %b want 1", err); end
    wait_beat(cyc);
    vectors++;
    if ({adr, last} !== {30'h77, 1'b1}) begin
      miscompares++; $display("FAIL err_beat got adr=%h last=%b want adr=77 last=1", adr, last);
    end
    @(negedge clk);
    vectors++;
    if ({busy, 32'(err_cnt - e0)} !== {1'b0, 32'd1}) begin
      miscompares++; $display("FAIL err_once got busy=%b pulses=%0d want busy=0 pulses=1", busy, err_cnt - e0);
    end
  endtask

  task automatic test_reset_mid_burst();
    int cyc;
    logic [29:0] e;
    apply_reset();
    fifo_ch = 3'd4;
    push(hdr(30'h1234, 1'b0, 2'b11, 3'b010));
    for (int i = 0; i < 3; i++) begin
      wait_beat(cyc);
      e = 30'h1230 | 30'((4 + i) % 16);
      vectors++;
      if ({adr, last} !== {e, 1'b0}) begin
        miscompares++; $display("FAIL w16_beat%0d got adr=%h last=%b want adr=%h last=0", i, adr, last, e);
      end
    end
    rst_n = 1'b0;
    @(negedge clk);
    vectors++;
    if ({b_re, fsel, rv, adr, we, dat, sel, port, last, busy, err} !== 78'd0) begin
      miscompares++;
      $display("FAIL midreset_outputs got %h want 0", {b_re, fsel, rv, adr, we, dat, sel, port, last, busy, err});
    end
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if ({b_re, rv, busy} !== 3'b000) begin
      miscompares++; $display("FAIL midreset_after got re=%b valid=%b busy=%b want 0 0 0", b_re, rv, busy);
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_wrap4_read();
    test_linear_read();
    test_wrap8_write();
    test_underflow_backpressure();
    test_round_robin();
    test_port_mask();
    test_reserved_cti();
    test_reset_mid_burst();
    vectors++;
    if (bad_pop !== 0) begin miscompares++; $display("FAIL pop_while_empty got %0d want 0", bad_pop); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sdram_tx_cmd_fetch.md
Name: sdram_tx_cmd_fetch

Overview:
- SDRAM-clock-side consumer (B side) of the multi-channel Wishbone tx FIFO.
- Selects a non-empty channel by round robin and pops a 36-bit header word {adr[31:2], we, bte[1:0], cti[2:0]}. For writes it also pops 36-bit data words {dat[31:0], sel[3:0]}.
- Expands each header into a per-beat request stream (valid/ready) toward the SDRAM command sequencer, generating Wishbone-compliant wrap addresses.

Parameters:
- PORT_MASK, 8'hFF, channel enable bitmap; disabled channels are never granted.
- LINEAR_LEN, 8, beat count for an incrementing burst with bte=00 (valid range 1..16).

Ports:
- sdram_clk  input  1  sole clock.
- sdram_rst_n  input  1  synchronous, active-low reset.
- b_fifo_empty_i  input  8  per-channel empty flags from the tx FIFO B side.
- b_dat_i  input  36  FIFO read data; valid exactly 1 cycle after b_re_o=1.
- b_re_o  output  1  FIFO pop strobe, one cycle per word.
- b_fifo_sel_o  output  3  channel being read; held stable for the whole burst.
- req_valid_o  output  1  beat request valid.
- req_ready_i  input  1  sequencer accepts the beat when valid&ready.
- req_adr_o  output  30  beat word address [31:2].
- req_we_o  output  1  1=write beat.
- req_dat_o  output  32  write data; 0 for reads.
- req_sel_o  output  4  byte enables; 4'hF for reads.
- req_port_o  output  3  originating channel.
- req_last_o  output  1  final beat of the burst.
- busy_o  output  1  high in any state other than IDLE.
- err_o  output  1  one-cycle pulse when a header with a reserved cti is captured.

Behaviour:
- Reset (sdram_rst_n=0 at a clock edge): state=IDLE; rr_ptr=7, so channel 0 has top priority first. All outputs 0, except req_sel_o=0 as well.
- Reset mid-burst aborts the burst immediately. No pops or requests occur in the following cycle. Words already popped are lost.
- Arbitration (IDLE only):
  - Candidates are channels with !b_fifo_empty_i & PORT_MASK.
  - Winner is the first candidate at index > rr_ptr, wrapping mod 8.
  - Winner is latched and the FSM moves to HDR_RD.
  - rr_ptr is updated to the winner only when the burst completes.
- States:
  - IDLE: wait for a candidate, latch winner → HDR_RD.
  - HDR_RD: b_re_o=1 for one cycle → HDR_CAP.
  - HDR_CAP: capture b_dat_i into adr/we/bte/cti and compute beats → ISSUE if we=0, DAT_RD if we=1.
  - DAT_RD: if empty[port]=0, b_re_o=1 → DAT_CAP; otherwise stall in DAT_RD indefinitely.
  - DAT_CAP: capture dat/sel → ISSUE.
  - ISSUE: req_valid_o=1; all req_* outputs held stable until req_ready_i=1.
    - On a non-last handshake: advance the address; read → stay in ISSUE, write → DAT_RD.
    - On the last handshake: update rr_ptr → IDLE.
- Beat count:
  - cti 000 or 111 → 1.
  - cti 010: bte 00 → LINEAR_LEN; 01 → 4; 10 → 8; 11 → 16.
  - cti 001 and 011..110 → 1 beat, with err_o pulsed in the HDR_CAP cycle.
- Address advance:
  - Linear: adr+1, modulo 2^30.
  - wrap4/8/16: increment only the low 2/3/4 bits modulo 4/8/16; upper bits unchanged.
- Timing and latency:
  - First req_valid_o rises 3 cycles after the IDLE cycle that sees a non-empty channel for reads, and 5 cycles after for writes.
  - Read beats issue back-to-back while req_ready_i=1.
  - Write beats issue at 1 per 3 cycles maximum.
- req_last_o=1 exactly on the beat where the beat counter reaches beats-1.
- b_re_o is never asserted when empty[b_fifo_sel_o]=1.
- A channel is never switched mid-burst.

Decomposition:
- Package sdram_tx_pkg holds:
  - header field positions: ADR 35:6, WE 5, BTE 4:3, CTI 2:0;
  - data field positions: DAT 35:4, SEL 3:0;
  - CTI/BTE encodings;
  - FSM state enum;
  - beat-count function;
  - wrap-increment function.
- Sub-module: rr_arb8, combinational round-robin winner from request[7:0] and rr_ptr. The FSM stays in the top module.

Test Plan:
- Single read: channel 3 header adr=0x123, we=0, cti=000 → b_re_o once with sel=3; one beat adr=0x123, last=1, port=3, sel=F; rr_ptr=3.
- Wrap4 read: adr=0x46, bte=01, cti=010, req_ready_i held 1 → beats 0x46, 0x47, 0x44, 0x45 on consecutive cycles; last only on 0x45.
- Wrap8 write: channel 5, adr=0x105, bte=10, plus 8 data words D0..D7 → adr 0x105, 0x106, 0x107, 0x100..0x104 carrying D0..D7 and their sel; 9 pops total.
- Write underflow plus backpressure: empty[5] raised after 2 data words for 10 cycles, and req_ready_i=0 for 4 cycles on beat 1 → FSM stalls in DAT_RD with no b_re_o; req_* held stable during backpressure; burst completes intact.
- Round robin: channels 0, 2, 6 all non-empty from reset → grant order 0, 2, 6, 0. With PORT_MASK=8'hFB, channel 2 is never granted.
- Reserved cti=011 → err_o pulses once; single beat issued. Reset asserted during beat 2 of a wrap16 read → next cycle has all outputs 0 and state IDLE.
